// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM state encoding (2 bits)
//   INST_W        : instruction word width
//   INST_NOP_WORD : word presented to the decoder when no instruction is valid
package fetch_unit_pkg;

  localparam int unsigned INST_W = 16;
  localparam logic [INST_W-1:0] INST_NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_ISSUE = 2'd2,
    FS_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack port.
//   imem_req   : fetch request (master -> memory)
//   imem_addr  : fetch address (master -> memory)
//   imem_ack   : data valid this cycle, meaningful only while imem_req=1 (memory -> master)
//   imem_rdata : instruction word (memory -> master)
// Modports: master = fetch unit side, slave = memory side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: asynchronous reset to RESET_PC, load has
// priority over increment, increment wraps modulo 2^ADDR_W.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle
//   load_val   : value to load
//   inc        : increment by one this cycle
//   pc         : current register value
module fetch_unit_pc_reg #(
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the decoder. Owns the PC, fetches one
// 16-bit word per FETCH/ISSUE pair over a req/ack port, presents it on INST
// for one issue cycle (longer under stall) and NOP otherwise.
//   clk        : system clock
//   res        : asynchronous active-low reset
//   imem       : instruction-memory port (master modport)
//   stall      : downstream not ready; hold INST/inst_valid
//   jmp        : single-cycle redirect pulse, target jmp_addr
//   hlt        : level; stop fetching while high
//   INST       : instruction to decoder (NOP when inst_valid=0)
//   inst_valid : INST holds a fetched instruction
//   PC         : address of next fetch
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               res,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               jmp,
  input  logic [ADDR_W-1:0]  jmp_addr,
  input  logic               hlt,
  output logic [INST_W-1:0]  INST,
  output logic               inst_valid,
  output logic [ADDR_W-1:0]  PC
);

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;

  fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (res),
    .load     (pc_load),
    .load_val (jmp_addr),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;

    if (jmp) begin
      // Redirect wins over everything: a coincident ack is dropped and the
      // pass through IDLE guarantees req is low for a cycle (memory abort).
      pc_load      = 1'b1;
      inst_d       = INST_NOP_WORD;
      inst_valid_d = 1'b0;
      state_d      = (state_q == FS_HALT && hlt) ? FS_HALT : FS_IDLE;
    end else begin
      case (state_q)
        FS_IDLE: begin
          state_d = hlt ? FS_HALT : FS_FETCH;
        end
        FS_FETCH: begin
          // hlt is ignored here: an outstanding request always completes.
          if (imem.imem_ack) begin
            inst_d       = imem.imem_rdata;
            inst_valid_d = 1'b1;
            pc_inc       = 1'b1;
            state_d      = FS_ISSUE;
          end
        end
        FS_ISSUE: begin
          if (!stall) begin
            inst_d       = INST_NOP_WORD;
            inst_valid_d = 1'b0;
            state_d      = hlt ? FS_HALT : FS_FETCH;
          end
        end
        FS_HALT: begin
          inst_d       = INST_NOP_WORD;
          inst_valid_d = 1'b0;
          if (!hlt) begin
            state_d = FS_FETCH;
          end
        end
        default: begin
          state_d = FS_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= FS_IDLE;
      inst_q       <= INST_NOP_WORD;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign imem.imem_req  = (state_q == FS_FETCH);
  assign imem.imem_addr = pc;
  assign INST           = inst_q;
  assign inst_valid     = inst_valid_q;
  assign PC             = pc;

endmodule
